// File: rtl/if_id_reg_pkg.sv
// Shared constants for the IF/ID pipeline register and the decoder.
// Holds the reset PC, the instruction-memory limit, the branch/jump encodings and the exception codes.
package if_id_reg_pkg;

    localparam logic [31:0] PKG_PC_RESET = 32'h0000_3000;
    localparam logic [31:0] PKG_IM_LAST  = 32'h0000_4FFF;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    typedef enum logic [4:0] {
        EXC_NONE = 5'd0,
        EXC_ADEL = 5'd4
    } exc_code_e;

endpackage

// File: rtl/if_id_reg_is_branch_jump.sv
// Combinational branch/jump classifier for a 32-bit instruction word.
// Shared between the IF/ID delay-slot tracking and the decoder.
module is_branch_jump
    import if_id_reg_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic        o_is_bj
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unused_fields;

    assign w_opcode        = i_instr[31:26];
    assign w_funct         = i_instr[5:0];
    assign w_unused_fields = ^i_instr[25:6];

    always_comb begin
        o_is_bj = 1'b0;
        case (w_opcode)
            OP_REGIMM, OP_J, OP_JAL,
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: o_is_bj = 1'b1;
            OP_SPECIAL: o_is_bj = (w_funct == FN_JR) || (w_funct == FN_JALR);
            default:    o_is_bj = 1'b0;
        endcase
    end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures the fetched instruction and PC, flags fetch
// address errors, tracks delay slots and counts instructions delivered to decode.
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PKG_PC_RESET,
    parameter logic [31:0] IM_LAST  = PKG_IM_LAST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_F,
    input  logic [31:0] PC_F,
    input  logic        EN,
    input  logic        flush,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC8_D,
    output logic        Valid_D,
    output logic        BD_D,
    output logic [4:0]  ExcCode_D,
    output logic [31:0] FetchCnt
);

    localparam logic [31:0] PC8_RESET = PC_RESET + 32'd8;

    // Declaration initialisers make the power-up state match the reset state.
    logic [31:0] r_instr_d   = '0;
    logic [31:0] r_pc_d      = PC_RESET;
    logic [31:0] r_pc8_d     = PC8_RESET;
    logic        r_valid_d   = 1'b0;
    logic        r_bd_d      = 1'b0;
    exc_code_e   r_exc_d     = EXC_NONE;
    logic [31:0] r_fetch_cnt = '0;

    logic w_fetch_err;
    logic w_cur_is_bj;

    assign w_fetch_err = (PC_F[1:0] != 2'b00) || (PC_F < PC_RESET) || (PC_F > IM_LAST);

    is_branch_jump u_is_branch_jump (
        .i_instr (r_instr_d),
        .o_is_bj (w_cur_is_bj)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_instr_d <= '0;
            r_pc_d    <= PC_RESET;
            r_pc8_d   <= PC8_RESET;
            r_valid_d <= 1'b0;
            r_bd_d    <= 1'b0;
            r_exc_d   <= EXC_NONE;
            if (reset) begin
                r_fetch_cnt <= '0;
            end
        end else if (EN) begin
            r_instr_d   <= w_fetch_err ? '0 : Instr_F;
            r_pc_d      <= PC_F;
            r_pc8_d     <= PC_F + 32'd8;
            r_valid_d   <= 1'b1;
            // The instruction now leaving D decides whether the new one sits in its delay slot.
            r_bd_d      <= w_cur_is_bj & r_valid_d;
            r_exc_d     <= w_fetch_err ? EXC_ADEL : EXC_NONE;
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign Instr_D   = r_instr_d;
    assign PC_D      = r_pc_d;
    assign PC8_D     = r_pc8_d;
    assign Valid_D   = r_valid_d;
    assign BD_D      = r_bd_d;
    assign ExcCode_D = r_exc_d;
    assign FetchCnt  = r_fetch_cnt;

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 Parameter PC_RESET, 32'h00003000, PC value loaded into PC_D on reset and flush.
REQ-002 Parameter IM_LAST, 32'h00004FFF, highest legal instruction byte address.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Instr_F  input  32  instruction word fetched at PC_F.
REQ-006 PC_F  input  32  fetch-stage program counter.
REQ-007 EN  input  1  1 = load new F-stage values; 0 = stall (hold contents).
REQ-008 flush  input  1  1 = replace contents with bubble at next edge.
REQ-009 Instr_D  output  32  registered instruction for decode stage.
REQ-010 PC_D  output  32  registered PC of Instr_D.
REQ-011 PC8_D  output  32  PC_D + 8 (link address), registered.
REQ-012 Valid_D  output  1  1 = D-stage holds a real fetched instruction.
REQ-013 BD_D  output  1  1 = Instr_D is in a branch/jump delay slot.
REQ-014 ExcCode_D  output  5  0 = none; 4 (AdEL) = fetch address error.
REQ-015 FetchCnt  output  32  count of instructions loaded into D-stage.

Function
REQ-016 Per-edge priority SHALL be: reset > flush > EN=0 hold > EN=1 load.
REQ-017 Load SHALL capture PC_F into PC_D, PC_F+8 (mod 2^32) into PC8_D, set Valid_D=1, in exactly one cycle latency.
REQ-018 Fetch error SHALL be PC_F[1:0]!=0, PC_F<PC_RESET, or PC_F>IM_LAST.
REQ-019 On load with fetch error, Instr_D SHALL be 32'h0, ExcCode_D=4; otherwise Instr_D=Instr_F, ExcCode_D=0.
REQ-020 On load, BD_D SHALL be 1 iff the current Instr_D (pre-edge) is a branch/jump and Valid_D=1.
REQ-021 Branch/jump set: opcode 000001, 000010, 000011, 000100, 000101, 000110, 000111; or opcode 000000 with funct 001000 (jr) or 001001 (jalr).
REQ-022 Hold (EN=0, flush=0) SHALL keep every output, including FetchCnt, unchanged.
REQ-023 Flush SHALL load bubble: Instr_D=0, PC_D=PC_RESET, PC8_D=PC_RESET+8, Valid_D=0, BD_D=0, ExcCode_D=0; flush overrides EN=0.
REQ-024 FetchCnt SHALL increment by 1 on every load (error loads included), wrap 32'hFFFFFFFF to 0, hold on hold/flush.
REQ-025 All outputs SHALL be driven directly from registers; no combinational path from inputs to outputs.

Reset
REQ-026 Reset SHALL set Instr_D=0, PC_D=PC_RESET, PC8_D=PC_RESET+8, Valid_D=0, BD_D=0, ExcCode_D=0, FetchCnt=0.
REQ-027 Reset asserted mid-stall or with flush SHALL win and produce the REQ-026 state at that edge.
REQ-028 Initial simulation values SHALL equal reset values.

Structure
REQ-029 Shared package SHALL hold PC_RESET, IM_LAST, opcode/funct constants of REQ-021, and ExcCode values (NONE=0, AdEL=4).
REQ-030 Branch/jump detection SHALL be one combinational sub-module, is_branch_jump (32-bit in, 1-bit out), reused later by the decoder.

Verification
REQ-031 reset=1 one edge, then EN=1 PC_F=3000 Instr_F=24010005 -> next edge Instr_D=24010005, PC_D=3000, PC8_D=3008, Valid_D=1, FetchCnt=1.
REQ-032 Instr_D=10220003 (beq) loaded, next load PC_F=3004 -> BD_D=1; following load PC_F=3008 (non-branch prior) -> BD_D=0.
REQ-033 EN=0 for 3 edges with changing Instr_F/PC_F -> all outputs constant; EN=0 with flush=1 -> bubble, FetchCnt unchanged.
REQ-034 Load PC_F=3002, then PC_F=5000, then PC_F=2FFC -> each gives Instr_D=0, ExcCode_D=4, Valid_D=1; PC_F=4FFC -> ExcCode_D=0.
REQ-035 FetchCnt forced to FFFFFFFF (via loads or hierarchical force), one load -> FetchCnt=0; reset with flush=1 and EN=1 -> REQ-026 state.
